// File: rtl/core_defs_pkg.sv
// Shared RV32I decode definitions: opcode constants, ALU operation encoding,
// the canonical NOP instruction, and the ID/EX pipeline register layout.
package core_defs;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassb = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rd_we;
        alu_op_e     alu_op;
        logic        alu_src_imm;
        logic [2:0]  funct3;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        is_auipc;
        logic        illegal;
    } id_ex_t;

    // ALU op for OP / OP-IMM; alt selects SUB/SRA (instruction bit 30).
    function automatic alu_op_e alu_op_of(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'd0:    return alt ? AluSub : AluAdd;
            3'd1:    return AluSll;
            3'd2:    return AluSlt;
            3'd3:    return AluSltu;
            3'd4:    return AluXor;
            3'd5:    return alt ? AluSra : AluSrl;
            3'd6:    return AluOr;
            default: return AluAnd;
        endcase
    endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 integer register file: two asynchronous read ports, one synchronous
// write port. x0 always reads zero and ignores writes. With BYPASS=1 a write
// in progress is forwarded to a read of the same register in the same cycle.
// Ports: clk; raddr1/rdata1, raddr2/rdata2 read ports; we/waddr/wdata write.
module regfile #(
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] mem [32];

    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = mem[raddr1];
        rdata2 = mem[raddr2];
        if (BYPASS && we && (waddr != 5'd0)) begin
            if (raddr1 == waddr) rdata1 = wdata;
            if (raddr2 == waddr) rdata2 = wdata;
        end
        if (raddr1 == 5'd0) rdata1 = 32'd0;
        if (raddr2 == 5'd0) rdata2 = 32'd0;
    end

endmodule

// File: rtl/idu.sv
// Instruction decode unit. Decodes RV32I from de_inst, reads operands from
// the owned register file, detects load-use hazards (id_stall, combinational)
// and registers the decoded instruction into the ID/EX boundary (ex_*).
// Ports: clk, rst_n (async active-low); de_valid/de_pc/de_inst from IF/ID;
// ex_flush from EX; wb_we/wb_rd/wb_data write-back; id_stall; ex_* to EX.
module idu
    import core_defs::*;
#(
    parameter logic [31:0] NOP_INST  = core_defs::NOP_INST,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de_valid,
    input  logic [31:0] de_pc,
    input  logic [31:0] de_inst,
    input  logic        ex_flush,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        id_stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic        ex_rd_we,
    output logic [3:0]  ex_alu_op,
    output logic        ex_alu_src_imm,
    output logic [2:0]  ex_funct3,
    output logic        ex_is_load,
    output logic        ex_is_store,
    output logic        ex_is_branch,
    output logic        ex_is_jal,
    output logic        ex_is_jalr,
    output logic        ex_is_auipc,
    output logic        ex_illegal
);

    // FENCE is substituted by the NOP encoding before decode.
    logic [31:0] inst;
    assign inst = (de_inst[6:0] == OPC_MISC_MEM && de_inst[14:12] == 3'd0) ? NOP_INST : de_inst;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'd0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    logic [31:0] rs1_data, rs2_data;

    regfile #(
        .BYPASS (WB_BYPASS)
    ) u_regfile (
        .clk    (clk),
        .raddr1 (rs1),
        .rdata1 (rs1_data),
        .raddr2 (rs2),
        .rdata2 (rs2_data),
        .we     (wb_we),
        .waddr  (wb_rd),
        .wdata  (wb_data)
    );

    id_ex_t dec;
    id_ex_t id_ex_d, id_ex_q;
    logic   writes_rd, rs1_used, rs2_used;

    always_comb begin
        dec          = '0;
        dec.valid    = de_valid;
        dec.pc       = de_pc;
        dec.rs1_data = rs1_data;
        dec.rs2_data = rs2_data;
        dec.rd       = rd;
        dec.funct3   = funct3;
        dec.alu_op   = AluAdd;
        writes_rd    = 1'b0;
        rs1_used     = 1'b0;
        rs2_used     = 1'b0;
        case (opcode)
            OPC_LUI: begin
                writes_rd = 1'b1; dec.alu_op = AluPassb; dec.alu_src_imm = 1'b1; dec.imm = imm_u;
            end
            OPC_AUIPC: begin
                writes_rd = 1'b1; dec.is_auipc = 1'b1; dec.alu_src_imm = 1'b1; dec.imm = imm_u;
            end
            OPC_JAL: begin
                writes_rd = 1'b1; dec.is_jal = 1'b1; dec.alu_src_imm = 1'b1; dec.imm = imm_j;
            end
            OPC_JALR: begin
                writes_rd = 1'b1; dec.is_jalr = 1'b1; dec.alu_src_imm = 1'b1; dec.imm = imm_i;
                rs1_used = 1'b1;
                dec.illegal = (funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                dec.is_branch = 1'b1; dec.alu_op = AluSub; dec.imm = imm_b;
                rs1_used = 1'b1; rs2_used = 1'b1;
                dec.illegal = (funct3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                writes_rd = 1'b1; dec.is_load = 1'b1; dec.alu_src_imm = 1'b1; dec.imm = imm_i;
                rs1_used = 1'b1;
                dec.illegal = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec.is_store = 1'b1; dec.alu_src_imm = 1'b1; dec.imm = imm_s;
                rs1_used = 1'b1; rs2_used = 1'b1;
                dec.illegal = (funct3 > 3'd2);
            end
            OPC_OP_IMM: begin
                writes_rd = 1'b1; dec.alu_src_imm = 1'b1; dec.imm = imm_i;
                rs1_used = 1'b1;
                // Only shifts carry a funct7 field; bit 30 selects SRAI.
                dec.alu_op = alu_op_of(funct3, (funct3 == 3'd5) && inst[30]);
                dec.illegal = ((funct3 == 3'd1) && (funct7 != 7'h00)) ||
                              ((funct3 == 3'd5) && (funct7 != 7'h00) && (funct7 != 7'h20));
            end
            OPC_OP: begin
                writes_rd = 1'b1;
                rs1_used = 1'b1; rs2_used = 1'b1;
                dec.alu_op = alu_op_of(funct3, inst[30]);
                dec.illegal = (funct7 != 7'h00) &&
                              !((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
            end
            default: dec.illegal = 1'b1;  // includes MISC-MEM other than FENCE
        endcase
        if (dec.illegal) begin
            writes_rd     = 1'b0;
            dec.is_load   = 1'b0;
            dec.is_store  = 1'b0;
            dec.is_branch = 1'b0;
            dec.is_jal    = 1'b0;
            dec.is_jalr   = 1'b0;
            dec.is_auipc  = 1'b0;
        end
        dec.rd_we = writes_rd && (rd != 5'd0);
    end

    assign id_stall = id_ex_q.valid && id_ex_q.is_load && id_ex_q.rd_we &&
                      ((rs1_used && (id_ex_q.rd == rs1)) || (rs2_used && (id_ex_q.rd == rs2))) &&
                      de_valid && !ex_flush;

    // Flush and stall both insert an all-zero bubble.
    assign id_ex_d = (ex_flush || id_stall) ? '0 : dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign ex_valid       = id_ex_q.valid;
    assign ex_pc          = id_ex_q.pc;
    assign ex_rs1_data    = id_ex_q.rs1_data;
    assign ex_rs2_data    = id_ex_q.rs2_data;
    assign ex_imm         = id_ex_q.imm;
    assign ex_rd          = id_ex_q.rd;
    assign ex_rd_we       = id_ex_q.rd_we;
    assign ex_alu_op      = id_ex_q.alu_op;
    assign ex_alu_src_imm = id_ex_q.alu_src_imm;
    assign ex_funct3      = id_ex_q.funct3;
    assign ex_is_load     = id_ex_q.is_load;
    assign ex_is_store    = id_ex_q.is_store;
    assign ex_is_branch   = id_ex_q.is_branch;
    assign ex_is_jal      = id_ex_q.is_jal;
    assign ex_is_jalr     = id_ex_q.is_jalr;
    assign ex_is_auipc    = id_ex_q.is_auipc;
    assign ex_illegal     = id_ex_q.illegal;

endmodule

// File: tb/tb_idu.sv
// Directed testbench for idu: one task per scenario, inline comparisons.
module tb_idu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        de_valid;
    logic [31:0] de_pc;
    logic [31:0] de_inst;
    logic        ex_flush;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        id_stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src_imm;
    logic [2:0]  ex_funct3;
    logic        ex_is_load;
    logic        ex_is_store;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic        ex_is_auipc;
    logic        ex_illegal;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] I_ADDI_X1_5  = 32'h0050_0093;
    localparam logic [31:0] I_ADD_X3_X2  = 32'h0021_01B3;
    localparam logic [31:0] I_LW_X5      = 32'h0000_A283;
    localparam logic [31:0] I_ADD_X6_X5  = 32'h0052_8333;
    localparam logic [31:0] I_ADDI_X6_X1 = 32'h0050_8313;
    localparam logic [31:0] I_ADD_X7_X0  = 32'h0000_03B3;
    localparam logic [31:0] I_SUB_X3     = 32'h4021_01B3;
    localparam logic [31:0] I_BAD_SLL    = 32'h4021_11B3;
    localparam logic [31:0] I_LUI_X10    = 32'h1234_5537;
    localparam logic [31:0] I_SW_M4      = 32'hFE20_AE23;
    localparam logic [31:0] I_FENCE      = 32'h0000_000F;

    idu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .de_valid       (de_valid),
        .de_pc          (de_pc),
        .de_inst        (de_inst),
        .ex_flush       (ex_flush),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .id_stall       (id_stall),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_rs1_data    (ex_rs1_data),
        .ex_rs2_data    (ex_rs2_data),
        .ex_imm         (ex_imm),
        .ex_rd          (ex_rd),
        .ex_rd_we       (ex_rd_we),
        .ex_alu_op      (ex_alu_op),
        .ex_alu_src_imm (ex_alu_src_imm),
        .ex_funct3      (ex_funct3),
        .ex_is_load     (ex_is_load),
        .ex_is_store    (ex_is_store),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jal      (ex_is_jal),
        .ex_is_jalr     (ex_is_jalr),
        .ex_is_auipc    (ex_is_auipc),
        .ex_illegal     (ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; de_valid = 1'b1; de_pc = 32'h40; de_inst = I_ADDI_X1_5;
        ex_flush = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
        checks++; if (ex_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", ex_pc); end
        step(); step();
        checks++; if (ex_rd_we !== 1'b0) begin errors++; $display("FAIL reset_rd_we: got %b want 0", ex_rd_we); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", id_stall); end
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        de_valid = 1'b1; de_pc = 32'h100; de_inst = I_ADDI_X1_5;
        step();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", ex_valid); end
        checks++; if (ex_pc !== 32'h100) begin errors++; $display("FAIL addi_pc: got %h want 100", ex_pc); end
        checks++; if (ex_rd !== 5'd1) begin errors++; $display("FAIL addi_rd: got %0d want 1", ex_rd); end
        checks++; if (ex_imm !== 32'd5) begin errors++; $display("FAIL addi_imm: got %h want 5", ex_imm); end
        checks++; if (ex_alu_op !== 4'd0) begin errors++; $display("FAIL addi_alu_op: got %0d want 0", ex_alu_op); end
        checks++; if (ex_alu_src_imm !== 1'b1) begin errors++; $display("FAIL addi_src_imm: got %b want 1", ex_alu_src_imm); end
        checks++; if (ex_rd_we !== 1'b1) begin errors++; $display("FAIL addi_rd_we: got %b want 1", ex_rd_we); end
    endtask

    task automatic test_bypass();
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEAD_BEEF;
        de_pc = 32'h104; de_inst = I_ADD_X3_X2;
        step();
        checks++; if (ex_rs1_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rs1: got %h want deadbeef", ex_rs1_data); end
        checks++; if (ex_rs2_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rs2: got %h want deadbeef", ex_rs2_data); end
        checks++; if (ex_rd !== 5'd3) begin errors++; $display("FAIL bypass_rd: got %0d want 3", ex_rd); end
        // Now read back from storage without the write in flight.
        wb_we = 1'b0; wb_data = 32'h0;
        step();
        checks++; if (ex_rs1_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stored_rs1: got %h want deadbeef", ex_rs1_data); end
        checks++; if (ex_rs2_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stored_rs2: got %h want deadbeef", ex_rs2_data); end
    endtask

    task automatic test_x0();
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234; de_inst = I_ADD_X7_X0;
        step();
        checks++; if (ex_rs1_data !== 32'd0) begin errors++; $display("FAIL x0_bypass_rs1: got %h want 0", ex_rs1_data); end
        checks++; if (ex_rs2_data !== 32'd0) begin errors++; $display("FAIL x0_bypass_rs2: got %h want 0", ex_rs2_data); end
        wb_we = 1'b0;
        step();
        checks++; if (ex_rs1_data !== 32'd0) begin errors++; $display("FAIL x0_rs1: got %h want 0", ex_rs1_data); end
        checks++; if (ex_rs2_data !== 32'd0) begin errors++; $display("FAIL x0_rs2: got %h want 0", ex_rs2_data); end
        checks++; if (ex_rd !== 5'd7) begin errors++; $display("FAIL x0_rd: got %0d want 7", ex_rd); end
    endtask

    task automatic test_load_use();
        de_inst = I_LW_X5;
        step();
        checks++; if (ex_is_load !== 1'b1) begin errors++; $display("FAIL lw_is_load: got %b want 1", ex_is_load); end
        de_inst = I_ADD_X6_X5;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", id_stall); end
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble_valid: got %b want 0", ex_valid); end
        checks++; if (ex_rd_we !== 1'b0) begin errors++; $display("FAIL lu_bubble_rd_we: got %b want 0", ex_rd_we); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_once: got %b want 0", id_stall); end
        step();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL lu_add_valid: got %b want 1", ex_valid); end
        checks++; if (ex_rd !== 5'd6) begin errors++; $display("FAIL lu_add_rd: got %0d want 6", ex_rd); end
        // I-type whose rs2 field matches the load rd must not stall.
        de_inst = I_LW_X5;
        step();
        de_inst = I_ADDI_X6_X1;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL itype_no_stall: got %b want 0", id_stall); end
        step();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL itype_valid: got %b want 1", ex_valid); end
    endtask

    task automatic test_flush();
        de_inst = I_LW_X5;
        step();
        de_inst = I_ADD_X6_X5; ex_flush = 1'b1;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", id_stall); end
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", ex_valid); end
        ex_flush = 1'b0;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL flush_after_stall: got %b want 0", id_stall); end
        step();
        checks++; if (ex_rd !== 5'd6 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL flush_resume: got rd=%0d valid=%b want rd=6 valid=1", ex_rd, ex_valid);
        end
    endtask

    task automatic test_decode();
        de_inst = 32'hFFFF_FFFF;
        step();
        checks++; if (ex_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag: got %b want 1", ex_illegal); end
        checks++; if (ex_rd_we !== 1'b0) begin errors++; $display("FAIL ill_rd_we: got %b want 0", ex_rd_we); end
        de_inst = I_SUB_X3;
        step();
        checks++; if (ex_alu_op !== 4'd1 || ex_illegal !== 1'b0) begin
            errors++; $display("FAIL sub_op: got op=%0d ill=%b want op=1 ill=0", ex_alu_op, ex_illegal);
        end
        de_inst = I_BAD_SLL;
        step();
        checks++; if (ex_illegal !== 1'b1 || ex_rd_we !== 1'b0) begin
            errors++; $display("FAIL bad_funct7: got ill=%b we=%b want ill=1 we=0", ex_illegal, ex_rd_we);
        end
        de_inst = I_LUI_X10;
        step();
        checks++; if (ex_imm !== 32'h1234_5000) begin errors++; $display("FAIL lui_imm: got %h want 12345000", ex_imm); end
        checks++; if (ex_alu_op !== 4'd10 || ex_rd !== 5'd10) begin
            errors++; $display("FAIL lui_op: got op=%0d rd=%0d want op=10 rd=10", ex_alu_op, ex_rd);
        end
        de_inst = I_SW_M4;
        step();
        checks++; if (ex_imm !== 32'hFFFF_FFFC) begin errors++; $display("FAIL sw_imm: got %h want fffffffc", ex_imm); end
        checks++; if (ex_is_store !== 1'b1 || ex_rd_we !== 1'b0) begin
            errors++; $display("FAIL sw_flags: got st=%b we=%b want st=1 we=0", ex_is_store, ex_rd_we);
        end
        de_inst = I_FENCE;
        step();
        checks++; if (ex_illegal !== 1'b0 || ex_rd_we !== 1'b0 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL fence_nop: got ill=%b we=%b valid=%b want 0 0 1", ex_illegal, ex_rd_we, ex_valid);
        end
    endtask

    task automatic test_async_reset();
        de_pc = 32'h200; de_inst = I_LW_X5;
        step();
        de_pc = 32'h204; de_inst = I_ADD_X6_X5;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL ar_pre_stall: got %b want 1", id_stall); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b0 || ex_is_load !== 1'b0) begin
            errors++; $display("FAIL ar_clear: got valid=%b load=%b want 0 0", ex_valid, ex_is_load);
        end
        checks++; if (ex_pc !== 32'd0 || ex_imm !== 32'd0 || ex_rd !== 5'd0) begin
            errors++; $display("FAIL ar_fields: got pc=%h imm=%h rd=%0d want 0", ex_pc, ex_imm, ex_rd);
        end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL ar_stall: got %b want 0", id_stall); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_pc !== 32'h204) begin
            errors++; $display("FAIL ar_resume: got valid=%b rd=%0d pc=%h want 1 6 204", ex_valid, ex_rd, ex_pc);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_bypass();
        test_x0();
        test_load_use();
        test_flush();
        test_decode();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
